// File: rtl/sigma_delta_cic_decimator.sv
// CIC decimator for the sigma-delta ADC path.
// Turns the 1-bit modulator stream into one ADC_BITLEN-wide sample per
// OVERSAMPLE_RATE clocks. DC gain is OVERSAMPLE_RATE**CIC_STAGES.
// All integrator and comb arithmetic wraps modulo 2**ADC_BITLEN.
`timescale 1ns/1ps

module sigma_delta_cic_decimator #(
  parameter int OVERSAMPLE_RATE = 256,
  parameter int CIC_STAGES      = 2,
  parameter int ADC_BITLEN      = 24,
  parameter bit SIGNED_OUTPUT   = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  pdm_in,
  output logic [ADC_BITLEN-1:0] pcm_out,
  output logic                  pcm_valid
);

  localparam int R  = OVERSAMPLE_RATE;
  localparam int N  = CIC_STAGES;
  localparam int W  = ADC_BITLEN;
  localparam int CW = (R > 1) ? $clog2(R) : 1;

  localparam logic [W-1:0] X_HIGH = W'(1);
  localparam logic [W-1:0] X_LOW  = SIGNED_OUTPUT ? '1 : '0;

  if (W < 2 + N * CW) begin : g_bad_width
    $error("sigma_delta_cic_decimator: ADC_BITLEN too small for CIC growth");
  end
  if ((R < 2) || ((R & (R - 1)) != 0)) begin : g_bad_rate
    $error("sigma_delta_cic_decimator: OVERSAMPLE_RATE must be a power of two >= 2");
  end
  if ((N < 1) || (N > 5)) begin : g_bad_stages
    $error("sigma_delta_cic_decimator: CIC_STAGES must be 1..5");
  end

  logic [W-1:0]  x;
  logic [CW-1:0] cnt;
  logic          cap;
  logic [N:0]    pipe_v;
  logic [W-1:0]  cap_reg;
  logic [W-1:0]  integ [N];
  logic [W-1:0]  comb  [N+1];

  // Map the bitstream to +1 / -1 (signed) or 1 / 0 (unsigned).
  always_comb begin
    x = pdm_in ? X_HIGH : X_LOW;
  end

  assign cap = (cnt == CW'(R - 1));

  // Integrator cascade at full rate; stage k feeds on stage k-1's register.
  for (genvar k = 0; k < N; k++) begin : g_integ
    logic [W-1:0] acc;
    logic [W-1:0] feed;
    if (k == 0) begin : g_head
      assign feed = x;
    end else begin : g_tail
      assign feed = integ[k-1];
    end
    // Accumulate this stage's input, wrapping modulo 2**W.
    always_ff @(posedge clk) begin
      if (!rst) acc <= '0;
      else      acc <= acc + feed;
    end
    assign integ[k] = acc;
  end

  // Decimation counter; R is a power of two so natural wrap gives 0..R-1.
  always_ff @(posedge clk) begin
    if (!rst) cnt <= '0;
    else      cnt <= cnt + CW'(1);
  end

  // Valid token walking through capture, each comb stage and the output.
  always_ff @(posedge clk) begin
    if (!rst) pipe_v <= '0;
    else      pipe_v <= {pipe_v[N-1:0], cap};
  end

  // Snapshot the last integrator once per decimated period.
  always_ff @(posedge clk) begin
    if (!rst)     cap_reg <= '0;
    else if (cap) cap_reg <= integ[N-1];
  end
  assign comb[0] = cap_reg;

  // Comb cascade: stage k fires one clock after stage k-1 produced its value.
  for (genvar k = 1; k <= N; k++) begin : g_comb
    logic [W-1:0] diff;
    logic [W-1:0] hold;
    // Difference against the previous decimated value of the stage input.
    always_ff @(posedge clk) begin
      if (!rst) begin
        diff <= '0;
        hold <= '0;
      end else if (pipe_v[k-1]) begin
        diff <= comb[k-1] - hold;
        hold <= comb[k-1];
      end
    end
    assign comb[k] = diff;
  end

  // Publish the last comb stage with a one-cycle strobe; hold between strobes.
  always_ff @(posedge clk) begin
    if (!rst) begin
      pcm_out   <= '0;
      pcm_valid <= 1'b0;
    end else begin
      pcm_valid <= pipe_v[N];
      if (pipe_v[N]) pcm_out <= comb[N];
    end
  end

  // The output slot may coincide with the next capture; the comb stages may not.
  a_no_overlap: assert property (@(posedge clk) disable iff (!rst)
    !(cap && (|pipe_v[N-1:0])));

endmodule
